// File: rtl/load_store_unit.sv
// Load/store unit between a requester and a single-ported-per-direction word memory.
// Sub-word stores are done as read-modify-write; loads extract and extend the addressed lane(s).
module load_store_unit #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH) + 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    // Handshake: a request is accepted in any cycle where req_valid_i && req_ready_o;
    // req_ready_o is high only in IDLE, and every accepted request yields exactly one
    // single-cycle rsp_valid_o pulse before the next request can be accepted.
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_wdata_i,

    output logic          rsp_valid_o,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,

    output logic          mem_read_en_o,
    output logic [AW-3:0] mem_read_pos_o,
    input  logic [31:0]   mem_read_data_i,
    input  logic          mem_read_valid_i,

    output logic          mem_write_en_o,
    output logic [AW-3:0] mem_write_pos_o,
    output logic [31:0]   mem_write_data_o,

    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        state_q;
    logic          we_q;
    logic          uns_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          req_err;
    logic [4:0]    shamt;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic [31:0]   lane_mask;
    logic [31:0]   merge_mask;
    logic [31:0]   merged;

    assign req_err = (req_size_i == 2'b11) ||
                     (req_size_i == 2'b01 && req_addr_i[0]) ||
                     (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

    // Lane 0 of 'shifted' holds the addressed byte/half (little-endian).
    always_comb begin
        shamt    = {addr_q[1:0], 3'b000};
        shifted  = mem_read_data_i >> shamt;
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        lane_mask  = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        merge_mask = lane_mask << shamt;
        merged     = (mem_read_data_i & ~merge_mask) | ((wdata_q << shamt) & merge_mask);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        uns_q       <= req_unsigned_i;
                        size_q      <= req_size_i;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        mem_wdata_q <= req_wdata_i;
                        rdata_q     <= '0;
                        err_q       <= req_err;
                        if (req_err)
                            state_q <= S_RESP;
                        else if (req_we_i && req_size_i == 2'b10)
                            state_q <= S_WRITE;
                        else
                            state_q <= S_READ;
                    end
                end
                S_READ:  state_q <= S_WAIT;
                S_WAIT: begin
                    if (mem_read_valid_i) begin
                        if (we_q) begin
                            mem_wdata_q <= merged;
                            state_q     <= S_WRITE;
                        end else begin
                            rdata_q <= load_ext;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_WRITE: state_q <= S_RESP;
                S_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o      = (state_q == S_IDLE);
    assign rsp_valid_o      = (state_q == S_RESP);
    assign rsp_rdata_o      = rdata_q;
    assign rsp_err_o        = err_q;
    assign mem_read_en_o    = (state_q == S_READ);
    assign mem_read_pos_o   = addr_q[AW-1:2];
    assign mem_write_en_o   = (state_q == S_WRITE);
    assign mem_write_pos_o  = addr_q[AW-1:2];
    assign mem_write_data_o = mem_wdata_q;
    assign dbg_state_o      = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words in the attached memory; AW = $clog2(DEPTH)+2 is the byte-address width.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  request present.
REQ-005 SHALL have port req_ready_o  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr_i  input  AW  byte address.
REQ-010 SHALL have port req_wdata_i  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata_o  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o  output  1  misaligned or illegal-size request.
REQ-014 SHALL have ports mem_read_en_o (output 1), mem_read_pos_o (output AW-2), mem_read_data_i (input 32), mem_read_valid_i (input 1): word-memory read port with one-cycle read latency.
REQ-015 SHALL have ports mem_write_en_o (output 1), mem_write_pos_o (output AW-2), mem_write_data_o (output 32): word-memory write port.

Function
REQ-016 SHALL implement states IDLE, READ, WAIT, WRITE, RESP, with req_ready_o = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid_i && req_ready_o and latch addr, size, we, unsigned and wdata; inputs are ignored in all other cycles.
REQ-018 SHALL flag an error when size = 11, when size = 01 && addr[0], or when size = 10 && addr[1:0] != 0; on error: IDLE -> RESP, no memory enable asserted, rsp_err_o = 1.
REQ-019 SHALL use word position addr[AW-1:2] and byte lane addr[1:0], little-endian.
REQ-020 SHALL route a load IDLE -> READ -> WAIT -> RESP: mem_read_en_o = 1 only in READ; rsp_valid_o is high 3 cycles after the accept.
REQ-021 SHALL route a word store IDLE -> WRITE -> RESP: mem_write_en_o = 1 only in WRITE with data = wdata; rsp_valid_o is high 2 cycles after the accept.
REQ-022 SHALL route a byte or half store IDLE -> READ -> WAIT -> WRITE -> RESP (read-modify-write): only the addressed lane(s) of the read word are replaced by wdata[7:0] or wdata[15:0]; rsp_valid_o is high 4 cycles after the accept.
REQ-023 SHALL remain in WAIT until mem_read_valid_i = 1, then capture mem_read_data_i.
REQ-024 SHALL extract a load result as byte data[8*lane+:8] or half data[8*lane+:16], then zero- or sign-extend it to 32 bits.
REQ-025 SHALL hold rsp_valid_o high for exactly one cycle (RESP); RESP -> IDLE, with req_ready_o high in the cycle after RESP.
REQ-026 SHALL decode mem_*_en_o directly from registered state (glitch-free); read and write enables are never both high in one cycle.
REQ-027 SHALL hold mem_*_pos_o and mem_write_data_o stable while the corresponding enable is high; their values are don't-care otherwise.

Reset
REQ-028 SHALL, when rst_ni = 0 at a clock edge, go to IDLE with rsp_valid_o, rsp_rdata_o, rsp_err_o, mem_read_en_o and mem_write_en_o all 0, and req_ready_o = 1 after the edge at which rst_ni = 1 is sampled.
REQ-029 SHALL drop any in-flight request on reset mid-operation: no pending write is issued and no response is produced for it.

Verification
REQ-030 SHALL pass: store word 0xDEADBEEF at addr 0x10 -> WRITE cycle with pos 4 and data 0xDEADBEEF, rsp err 0 at +2; then load word 0x10 -> rdata 0xDEADBEEF at +3.
REQ-031 SHALL pass: with word 4 = 0xDEADBEEF, load byte addr 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half addr 0x12 signed -> 0xFFFFDEAD.
REQ-032 SHALL pass: store byte 0x55 at addr 0x11 -> read pos 4, then write pos 4 with data 0xDEAD55EF, rsp at +4.
REQ-033 SHALL pass: load half at addr 0x11, and separately size = 11 -> rsp_err_o = 1 and rdata 0 at +1, no mem enable asserted.
REQ-034 SHALL pass: rst_ni low during WAIT of a byte store -> mem_write_en_o never asserted, memory word unchanged, req_ready_o = 1 after release.
REQ-035 SHALL pass: req_valid_i held high continuously -> exactly one accept per transaction, and the next accept occurs only in the cycle after RESP.
